// File: rtl/bounce_if.sv
// Command/status bundle between a stimulus source and the bounce emulator.
interface bounce_if;
   logic en;
   logic clean_in;
   logic noisy_out;
   logic busy;
   logic done;

   modport master (output en, output clean_in, input noisy_out, input busy, input done);
   modport slave  (input en, input clean_in, output noisy_out, output busy, output done);
endinterface

// File: rtl/bounce_emulator.sv
// Turns a clean commanded level into a reproducible bouncing contact waveform.
// state  | meaning
// IDLE   | output equals target, waiting for a new command
// BOUNCE | emitting toggles spaced by LFSR-derived gaps
// SETTLE | output held, counting down to the done pulse
module bounce_emulator #(
   parameter int          BOUNCES    = 3,
   parameter int          MIN_GAP    = 4,
   parameter logic [15:0] GAP_MASK   = 16'h003F,
   parameter int          SETTLE_CYC = 100,
   parameter int          CNT_W      = 16,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic     clk,
   input  logic     rst,
   bounce_if.slave  bus
);

   localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] TAPS    = 16'hB400;
   localparam int          REM_W   = (BOUNCES > 0) ? $clog2(2 * BOUNCES + 1) : 1;
   localparam logic [REM_W-1:0] REM_INIT  = REM_W'(2 * BOUNCES);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

   typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

   state_t           state;
   logic [15:0]      lfsr;
   logic [CNT_W-1:0] gap;
   logic [CNT_W-1:0] gap_cnt;
   logic [CNT_W-1:0] settle_cnt;
   logic [REM_W-1:0] remaining;
   logic             target;
   logic             noisy;
   logic             busy_r;
   logic             done_r;
   logic             chg;

   assign gap = CNT_W'(MIN_GAP) + CNT_W'(lfsr & GAP_MASK);
   assign chg = (bus.clean_in != target);

   // Free-running so the gap sequence depends only on time since reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= SEED_NZ;
      else if (lfsr[0])
         lfsr <= (lfsr >> 1) ^ TAPS;
      else
         lfsr <= lfsr >> 1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         target     <= 1'b0;
         noisy      <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         gap_cnt    <= '0;
         settle_cnt <= '0;
         remaining  <= '0;
      end else begin
         done_r <= 1'b0;
         if (!bus.en) begin
            state      <= IDLE;
            target     <= bus.clean_in;
            noisy      <= bus.clean_in;
            busy_r     <= 1'b0;
            gap_cnt    <= '0;
            settle_cnt <= '0;
            remaining  <= '0;
         end else if (chg) begin
            // A new command always restarts from first contact, whatever the state.
            target    <= bus.clean_in;
            noisy     <= bus.clean_in;
            busy_r    <= 1'b1;
            remaining <= REM_INIT;
            gap_cnt   <= gap;
            if (BOUNCES == 0) begin
               state      <= SETTLE;
               settle_cnt <= SETTLE_LD;
            end else begin
               state <= BOUNCE;
            end
         end else begin
            case (state)
               BOUNCE: begin
                  if (gap_cnt == CNT_W'(1)) begin
                     noisy     <= ~noisy;
                     remaining <= remaining - REM_W'(1);
                     gap_cnt   <= gap;
                     if (remaining == REM_W'(1)) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LD;
                     end
                  end else begin
                     gap_cnt <= gap_cnt - CNT_W'(1);
                  end
               end
               SETTLE: begin
                  if (settle_cnt == CNT_W'(1)) begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt - CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.noisy_out = noisy;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

endmodule
